// File: rtl/modo_monitor.sv
// modo_monitor: checks an external 4-bit modo counter against a cycle-by-cycle prediction.
// Define MODO_MON_RCO_CHK_EN to also compare rco (err_code bit 1); otherwise only q is checked.
module modo_monitor (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] modo,
    input  logic [3:0] d,
    input  logic [3:0] q,
    input  logic       rco,
    input  logic       err_clr,
    output logic       err,
    output logic       err_q,
    output logic [1:0] err_code,
    output logic [7:0] wrap_cnt,
    output logic       synced
);
    typedef enum logic [1:0] {UNSYNC, RST_CHK, TRACK} state_t;
    state_t     state_q, state_d;
    logic [3:0] exp_val_q, exp_val_d, pred_val;
    logic       pulse_q, pulse_d, sticky_q, sticky_d;
    logic [1:0] code_q, code_d, miss;
    logic [7:0] wrap_q, wrap_d;
    logic       miss_rco;
    // Predictions use the observed q, so a mismatch resynchronises automatically.
    always_comb begin
        pred_val = !enable ? q :
                   modo == 2'd0 ? q + 4'd1 :
                   modo == 2'd1 ? q - 4'd1 :
                   modo == 2'd2 ? (q <= 4'd2 ? q + 4'd12 : q - 4'd3) : d;
    end
`ifdef MODO_MON_RCO_CHK_EN
    logic exp_rco_q, pred_rco;
    always_comb begin
        pred_rco = enable && (modo == 2'd0 ? q == 4'd15 :
                              modo == 2'd1 ? q == 4'd0 :
                              modo == 2'd2 ? q <= 4'd2 : 1'b0);
    end
    always_ff @(posedge clk) exp_rco_q <= rst ? 1'b0 : pred_rco;
    assign miss_rco = rco != exp_rco_q;
`else
    assign miss_rco = 1'b0;
`endif
    always_comb begin
        miss      = state_q == UNSYNC ? 2'b00 : {miss_rco, q != exp_val_q};
        state_d   = state_q == UNSYNC && !(enable && modo == 2'd3) ? UNSYNC : TRACK;
        exp_val_d = pred_val;
        pulse_d   = |miss;
        sticky_d  = |miss | (sticky_q & ~err_clr);
        code_d    = |miss ? miss : err_clr ? 2'b00 : code_q;
        wrap_d    = rco && wrap_q != 8'hff ? wrap_q + 8'd1 : wrap_q;
        if (rst) begin
            state_d   = modo == 2'd3 ? UNSYNC : RST_CHK;
            exp_val_d = modo == 2'd0 ? 4'd0 : 4'd15;
            pulse_d   = 1'b0;
            sticky_d  = 1'b0;
            code_d    = 2'b00;
            wrap_d    = 8'd0;
        end
    end
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        exp_val_q <= exp_val_d;
        pulse_q   <= pulse_d;
        sticky_q  <= sticky_d;
        code_q    <= code_d;
        wrap_q    <= wrap_d;
    end
    assign err      = pulse_q;
    assign err_q    = sticky_q;
    assign err_code = code_q;
    assign wrap_cnt = wrap_q;
    assign synced   = state_q == TRACK || state_q == RST_CHK;
endmodule

// File: doc/modo_monitor.md
MODO_MONITOR -- requirements
Module: modo_monitor

Interface
REQ-001 clk  in  1  single clock; every register updates on rising edge only.
REQ-002 rst  in  1  synchronous, active-high reset of monitor, and marks reset of the observed counter.
REQ-003 enable  in  1  counter enable, as driven to the observed counter.
REQ-004 modo  in  2  counter mode: 0 up, 1 down, 2 down-by-3, 3 load.
REQ-005 d  in  4  counter load data.
REQ-006 q  in  4  observed counter value.
REQ-007 rco  in  1  observed counter ripple-carry-out.
REQ-008 err_clr  in  1  clears sticky error and err_code.
REQ-009 err  out  1  one-cycle pulse per detected mismatch.
REQ-010 err_q  out  1  sticky error flag.
REQ-011 err_code  out  2  last mismatch: 00 none, 01 q, 10 rco, 11 both.
REQ-012 wrap_cnt  out  8  saturating count of observed rco pulses.
REQ-013 synced  out  1  high while state is TRACK or RST_CHK.

Function
REQ-014 Monitor SHALL sample all inputs each rising edge; expectation for sample k+1 derives solely from sample k.
REQ-015 Expected next q, with enable=1: modo 0: q+1, 15->0; modo 1: q-1, 0->15; modo 2: q-3, 0->12, 1->13, 2->14; modo 3: d.
REQ-016 Expected next rco SHALL be 1 only on the wrap cases of REQ-015 (modo 0 at 15, modo 1 at 0, modo 2 at q<=2), otherwise 0; modo 3 always 0.
REQ-017 With enable=0, expected next q SHALL equal current q and expected rco SHALL be 0.
REQ-018 A modo change takes effect on expectation from the sample in which the new modo is first seen; no extra latency.
REQ-019 States: UNSYNC, RST_CHK, TRACK.
REQ-020 Any sample with rst=1 -> RST_CHK, expected q 0 (modo 0) or 15 (modo 1/2), expected rco 0; if modo=3 -> UNSYNC.
REQ-021 RST_CHK: compare first non-reset sample against reset expectation, then TRACK.
REQ-022 TRACK: compare every sample against expectation from prior sample.
REQ-023 UNSYNC: no comparisons; a sample with enable=1 and modo=3 -> TRACK, expecting q=d next.
REQ-024 On mismatch: err=1 for exactly the cycle following the offending sample edge, err_q set, err_code updated, state stays TRACK and resynchronises to observed q.
REQ-025 No mismatch: err=0; err_code and err_q unchanged.
REQ-026 err_clr=1 SHALL clear err_q and err_code; a mismatch in the same sample wins (flags set).
REQ-027 wrap_cnt SHALL increment on each non-reset sample with rco=1, saturating at 255; counts regardless of state.
REQ-028 All width arithmetic is modulo-16 on q predictions; no out-of-range expected values.

Reset
REQ-029 Synchronous rst SHALL force err=0, err_q=0, err_code=00, wrap_cnt=0, and state per REQ-020; synced=1 only if entering RST_CHK.
REQ-030 rst asserted mid-operation SHALL abandon the pending comparison; no err generated for that sample.

Configuration
REQ-031 Macro MODO_MON_RCO_CHK_EN defined: rco compared per REQ-016; err_code bit 1 functional.
REQ-032 MODO_MON_RCO_CHK_EN undefined: only q compared; err_code bit 1 tied 0; wrap_cnt still functional.

Verification
REQ-033 rst with modo=0, then enable=1 modo=0 for 17 cycles, q 0..15,0, rco=1 at the wrap -> err never asserted, wrap_cnt=1.
REQ-034 TRACK modo=1, q sequence 3,2,2 -> err pulses once at the third sample, err_code=01, err_q=1.
REQ-035 modo=2 from q=1, observed next q=13, rco=0 -> with macro err_code=10; without macro no err.
REQ-036 rst with modo=3 -> synced=0, arbitrary q produces no err; enable=1 modo=3 d=9, next q=9 -> synced=1, no err.
REQ-037 Mismatch and err_clr in same sample -> err_q=1 after edge; err_clr alone next cycle -> err_q=0, err_code=00.
REQ-038 256 rco pulses -> wrap_cnt=255 held; rst -> wrap_cnt=0.
